score_keeper: RTL and testbench

//   Producer side of the two-digit score display path: maintains the 0-99 game score that the

---
 rtl/score_pkg.sv | 12 +
 rtl/rise_edge_det.sv | 25 ++
 rtl/score_keeper.sv | 121 ++++++++++++
 tb/tb_score_keeper.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared score definitions for the score keeper and the seven-segment display stage.
package score_pkg;

    localparam int SCORE_W     = 7;
    localparam int DISPLAY_MAX = 99;

    typedef enum logic [0:0] {
        ST_PLAYING = 1'b0,
        ST_WON     = 1'b1
    } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a single-level game event input.
module rise_edge_det (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_in,
    output logic o_rise
);

    logic r_in_q;
    logic r_armed;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_in_q  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_in_q  <= i_in;
            r_armed <= 1'b1;
        end
    end

    // r_armed masks the first cycle after reset so a level already high is not an edge.
    assign o_rise = i_in & ~r_in_q & r_armed;

endmodule

// File: rtl/score_keeper.sv
// Saturating 0..MAX_SCORE game score with win tracking and a one-cycle change strobe.
module score_keeper
    import score_pkg::*;
#(
    parameter int MAX_SCORE = DISPLAY_MAX,
    parameter int WIN_SCORE = 21,
    parameter int PTS_W     = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_add_evt,
    input  logic               i_sub_evt,
    input  logic [PTS_W-1:0]   i_pt_value,
    input  logic               i_clear,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_score_changed,
    output logic               o_at_max,
    output logic               o_win,
    output state_t             o_state
);

    localparam int                 CALC_W = 8;
    localparam logic [CALC_W-1:0]  MAX8   = CALC_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX7   = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] WIN7   = SCORE_W'(WIN_SCORE);

    logic               w_add_rise;
    logic               w_sub_rise;
    logic [CALC_W-1:0]  w_pt8;
    logic [CALC_W-1:0]  w_score8;
    logic [CALC_W-1:0]  w_add_amt;
    logic [CALC_W-1:0]  w_sub_amt;
    logic [CALC_W-1:0]  w_sum;
    logic [CALC_W-1:0]  w_delta;
    logic [CALC_W-1:0]  w_diff;
    logic [SCORE_W-1:0] w_next_score;
    state_t             w_next_state;

    logic [SCORE_W-1:0] r_score;
    logic               r_changed;
    state_t             r_state;

    rise_edge_det u_add_det (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_in      (i_add_evt),
        .o_rise    (w_add_rise)
    );

    rise_edge_det u_sub_det (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_in      (i_sub_evt),
        .o_rise    (w_sub_rise)
    );

    assign w_pt8     = CALC_W'(i_pt_value);
    assign w_score8  = CALC_W'(r_score);
    assign w_add_amt = w_add_rise ? w_pt8 : '0;
    assign w_sub_amt = w_sub_rise ? w_pt8 : '0;

    always_comb begin
        w_next_score = r_score;
        w_next_state = r_state;
        w_sum        = '0;
        w_delta      = '0;
        w_diff       = '0;
        if (i_clear) begin
            w_next_score = '0;
            w_next_state = ST_PLAYING;
        end else begin
            case (r_state)
                ST_PLAYING: begin
                    // Simultaneous add and sub collapse to one net adjustment.
                    if (w_add_amt >= w_sub_amt) begin
                        w_sum        = w_score8 + (w_add_amt - w_sub_amt);
                        w_next_score = (w_sum > MAX8) ? MAX7 : SCORE_W'(w_sum);
                    end else begin
                        w_delta      = w_sub_amt - w_add_amt;
                        w_diff       = w_score8 - w_delta;
                        w_next_score = (w_delta > w_score8) ? '0 : SCORE_W'(w_diff);
                    end
                    if (w_next_score >= WIN7) begin
                        w_next_state = ST_WON;
                    end
                end
                ST_WON: begin
                    w_next_state = ST_WON;
                end
                default: begin
                    w_next_state = ST_PLAYING;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_PLAYING;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_score   <= '0;
            r_changed <= 1'b0;
        end else begin
            r_score   <= w_next_score;
            r_changed <= (w_next_score != r_score);
        end
    end

    assign o_score         = r_score;
    assign o_score_changed = r_changed;
    assign o_at_max        = (r_score == MAX7);
    assign o_win           = (r_state == ST_WON);
    assign o_state         = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: default build plus a WIN_SCORE=99 build for clamp checks.
module tb_score_keeper;
    import score_pkg::*;

    logic       clk;
    logic       reset_n;

    logic       add_a, sub_a, clr_a;
    logic [3:0] pt_a;
    logic [6:0] score_a;
    logic       chg_a, max_a, win_a;
    state_t     st_a;

    logic       add_b, sub_b, clr_b;
    logic [3:0] pt_b;
    logic [6:0] score_b;
    logic       chg_b, max_b, win_b;
    state_t     st_b;

    int n_checks;
    int n_fail;

    score_keeper u_dut_a (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_add_evt       (add_a),
        .i_sub_evt       (sub_a),
        .i_pt_value      (pt_a),
        .i_clear         (clr_a),
        .o_score         (score_a),
        .o_score_changed (chg_a),
        .o_at_max        (max_a),
        .o_win           (win_a),
        .o_state         (st_a)
    );

    score_keeper #(.WIN_SCORE(99)) u_dut_b (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_add_evt       (add_b),
        .i_sub_evt       (sub_b),
        .i_pt_value      (pt_b),
        .i_clear         (clr_b),
        .o_score         (score_b),
        .o_score_changed (chg_b),
        .o_at_max        (max_b),
        .o_win           (win_b),
        .o_state         (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_b_add(input logic [3:0] pt);
        add_b = 1'b1;
        pt_b  = pt;
        tick();
        add_b = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        add_a = 1'b1; sub_a = 1'b0; clr_a = 1'b0; pt_a = 4'd3;
        add_b = 1'b0; sub_b = 1'b0; clr_b = 1'b0; pt_b = 4'd0;

        // Reset with add level held high
        tick(); tick(); tick();
        check("rst_score", score_a, 0);
        check("rst_win", win_a, 0);
        check("rst_chg", chg_a, 0);
        check("rst_state", st_a, ST_PLAYING);
        check("rst_max", max_a, 0);
        reset_n = 1'b1;
        tick();
        check("rel_score", score_a, 0);
        check("rel_chg", chg_a, 0);
        tick();
        check("rel_score2", score_a, 0);
        check("rel_chg2", chg_a, 0);
        add_a = 1'b0;
        tick();
        check("rel_score3", score_a, 0);

        // Three adds of 3
        for (int k = 1; k <= 3; k++) begin
            add_a = 1'b1;
            tick();
            check("add_score", score_a, 3 * k);
            check("add_chg", chg_a, 1);
            add_a = 1'b0;
            tick();
            check("add_hold", score_a, 3 * k);
            check("add_chg_off", chg_a, 0);
        end

        // Move to 10, then simultaneous add/sub of 4
        pt_a = 4'd1; add_a = 1'b1; tick();
        check("to10", score_a, 10);
        add_a = 1'b0; tick();
        pt_a = 4'd4; add_a = 1'b1; sub_a = 1'b1; tick();
        check("simul_score", score_a, 10);
        check("simul_chg", chg_a, 0);
        add_a = 1'b0; sub_a = 1'b0; tick();

        // Down to 5, then clear beats an add rise
        pt_a = 4'd5; sub_a = 1'b1; tick();
        check("to5", score_a, 5);
        sub_a = 1'b0; tick();
        clr_a = 1'b1; add_a = 1'b1; pt_a = 4'd3; tick();
        check("clrpri_score", score_a, 0);
        check("clrpri_chg", chg_a, 1);
        clr_a = 1'b0; tick();
        check("clrpri_after", score_a, 0);
        check("clrpri_chg2", chg_a, 0);
        add_a = 1'b0; tick();

        // Zero-point event
        pt_a = 4'd0; add_a = 1'b1; tick();
        check("pt0_score", score_a, 0);
        check("pt0_chg", chg_a, 0);
        add_a = 1'b0; tick();

        // Win at 21
        pt_a = 4'd15; add_a = 1'b1; tick();
        check("to15", score_a, 15);
        add_a = 1'b0; tick();
        pt_a = 4'd4; add_a = 1'b1; tick();
        check("to19", score_a, 19);
        check("win19", win_a, 0);
        add_a = 1'b0; tick();
        pt_a = 4'd2; add_a = 1'b1; tick();
        check("win_score", score_a, 21);
        check("win_flag", win_a, 1);
        check("win_state", st_a, ST_WON);
        check("win_chg", chg_a, 1);
        add_a = 1'b0; tick();
        check("win_chg_off", chg_a, 0);
        pt_a = 4'd5; add_a = 1'b1; tick();
        check("frozen_add", score_a, 21);
        check("frozen_chg", chg_a, 0);
        add_a = 1'b0; sub_a = 1'b1; tick();
        check("frozen_sub", score_a, 21);
        check("frozen_win", win_a, 1);
        sub_a = 1'b0; clr_a = 1'b1; tick();
        check("wclr_score", score_a, 0);
        check("wclr_win", win_a, 0);
        check("wclr_chg", chg_a, 1);
        check("wclr_state", st_a, ST_PLAYING);
        clr_a = 1'b0; tick();
        check("wclr_chg_off", chg_a, 0);
        pt_a = 4'd2; add_a = 1'b1; tick();
        check("resume", score_a, 2);
        add_a = 1'b0; tick();

        // Ceiling and floor on the WIN_SCORE=99 build
        for (int k = 0; k < 6; k++) pulse_b_add(4'd15);
        check("b_90", score_b, 90);
        pulse_b_add(4'd7);
        check("b_97", score_b, 97);
        check("b_97_max", max_b, 0);
        add_b = 1'b1; pt_b = 4'd5; tick();
        check("b_sat", score_b, 99);
        check("b_sat_max", max_b, 1);
        check("b_sat_chg", chg_b, 1);
        add_b = 1'b0; clr_b = 1'b1; tick();
        check("b_clr", score_b, 0);
        check("b_clr_max", max_b, 0);
        clr_b = 1'b0; tick();
        pulse_b_add(4'd2);
        check("b_2", score_b, 2);
        sub_b = 1'b1; pt_b = 4'd7; tick();
        check("b_floor", score_b, 0);
        check("b_floor_chg", chg_b, 1);
        sub_b = 1'b0; tick();
        sub_b = 1'b1; tick();
        check("b_floor2", score_b, 0);
        check("b_floor2_chg", chg_b, 0);
        sub_b = 1'b0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
